ets_edge_tdc: RTL

- Consumes the parallel comparator sample words produced each adc_clk by the comparator deserializer stage.
- After an arm request, scans successive words for the first 0->1 transition of the comparator output.
- Reports its position as a sample-resolution timestamp relative to the arm point. This is the fine-time measurement that feeds the ETS sequencer/histogram logic downstream.
- Output uses a valid/ready handshake.

---
 rtl/ets_pkg.sv | 19 +
 rtl/ets_edge_prienc.sv | 25 ++
 rtl/ets_edge_tdc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ets_pkg.sv
// Shared types and constants for the equivalent-time-sampling edge TDC:
// FSM state encoding, default geometry and the timeout timestamp code.
package ets_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int LANES_DEF = 4;
  localparam int CNT_W_DEF = 12;

  // Timestamps are CNT_W+3 bits wide; a timeout reports all ones.
  function automatic logic [31:0] timeout_code(input int cnt_w);
    return (32'd1 << (cnt_w + 3)) - 32'd1;
  endfunction

endpackage

// File: rtl/ets_edge_prienc.sv
// Combinational priority finder for the earliest 0->1 transition in {prev, word}.
// Bit LANES is the previous (oldest) sample; a higher index means an earlier sample.
module ets_edge_prienc
  import ets_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic [LANES:0] vec,
  output logic           found,
  output logic [2:0]     idx
);

  // Ascending scan so the highest (earliest) matching index is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      if (vec[i] && !vec[i+1]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/ets_edge_tdc.sv
// Armed first-edge timestamper over LANES-wide sample words; result one cycle after the edge word, held under ts_valid/ts_ready.
// ETS_FALLING_EDGE_EN adds edge_sel/ts_edge for falling-edge measurements.
module ets_edge_tdc
  import ets_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_WORDS = 4095
) (
  input  logic             adc_clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [7:0]       data_in,
  input  logic             data_ce,
`ifdef ETS_FALLING_EDGE_EN
  input  logic             edge_sel,
  output logic             ts_edge,
`endif
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [CNT_W+2:0] ts_data,
  output logic             ts_timeout,
  output logic             busy
);

  localparam int TS_W = CNT_W + 3;
  localparam logic [TS_W-1:0]  TS_TIMEOUT = TS_W'(timeout_code(CNT_W));
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(MAX_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             prev_bit_q, prev_bit_d;
  logic [TS_W-1:0]  ts_data_q, ts_data_d;
  logic             ts_timeout_q, ts_timeout_d;
  logic             edge_sel_q, edge_sel_d;

  logic             arm_sel;
  logic [LANES:0]   search_vec;
  logic             found;
  logic [2:0]       idx;
  logic [TS_W-1:0]  word_base;
  logic             unused_data;

`ifdef ETS_FALLING_EDGE_EN
  assign arm_sel = edge_sel;
`else
  assign arm_sel = 1'b0;
`endif

  assign unused_data = ^data_in;

  // prev_bit is kept in the raw sense; inversion covers it too, so falling mode searches rising edges.
  assign search_vec = {prev_bit_q, data_in[LANES-1:0]} ^ {(LANES+1){edge_sel_q}};
  assign word_base  = {3'b000, word_cnt_q} * TS_W'(LANES);

  ets_edge_prienc #(.LANES(LANES)) u_prienc (
    .vec   (search_vec),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      prev_bit_q   <= 1'b1;
      ts_data_q    <= '0;
      ts_timeout_q <= 1'b0;
      edge_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      prev_bit_q   <= prev_bit_d;
      ts_data_q    <= ts_data_d;
      ts_timeout_q <= ts_timeout_d;
      edge_sel_q   <= edge_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    prev_bit_d   = prev_bit_q;
    ts_data_d    = ts_data_q;
    ts_timeout_d = ts_timeout_q;
    edge_sel_d   = edge_sel_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = SEARCH;
          word_cnt_d = '0;
          edge_sel_d = arm_sel;
          prev_bit_d = ~arm_sel;
        end
      end
      SEARCH: begin
        if (data_ce) begin
          if (found) begin
            state_d      = HOLD;
            ts_data_d    = word_base + TS_W'(LANES - 1) - {{CNT_W{1'b0}}, idx};
            ts_timeout_d = 1'b0;
          end else begin
            prev_bit_d = data_in[0];
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (word_cnt_q == LAST_WORD) begin
              state_d      = HOLD;
              ts_data_d    = TS_TIMEOUT;
              ts_timeout_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (ts_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_valid   = (state_q == HOLD);
    busy       = (state_q != IDLE);
    ts_data    = ts_data_q;
    ts_timeout = ts_timeout_q;
`ifdef ETS_FALLING_EDGE_EN
    ts_edge    = edge_sel_q;
`endif
  end

endmodule
